// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage. Owns the fetch PC, drives an SRAM-like instruction
// bus (req / addr_ok / data_ok) with at most one transaction outstanding, and
// presents fetches to the IF/ID pipeline register.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   ID_stall            ID cannot accept the presented fetch this cycle
//   redirect_valid/_pc  branch/exception redirect (highest priority)
//   inst_*              instruction bus master side (read-only, word size)
//   IF_out_PC, IF_inst  PC and instruction of the presented fetch
//   IF_AdEF_exception   presented fetch has a misaligned PC
//   IF_bad_inst         faulting address when AdEF, else 0
//   IF_stall            no valid fetch presented this cycle
//   IF_invalid          flush IF/ID this cycle (mirrors redirect_valid)
//
// Optional feature (macro FETCH_PERF_CNT_EN):
//   fetch_cnt   accepted fetches (IF_stall=0 and ~ID_stall)
//   cancel_cnt  data beats discarded because of a redirect
// ----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] IF_out_PC,
  output logic [31:0] IF_inst,
  output logic        IF_AdEF_exception,
  output logic [31:0] IF_bad_inst,
  output logic        IF_stall,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_cnt,
  output logic [31:0] cancel_cnt,
`endif
  output logic        IF_invalid
);

  localparam logic [1:0] S_REQ       = 2'd0;
  localparam logic [1:0] S_WAIT_ADDR = 2'd1;
  localparam logic [1:0] S_WAIT_DATA = 2'd2;
  localparam logic [1:0] S_HOLD      = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] req_addr;   // address of the request parked in WAIT_ADDR
  logic [31:0] hold_inst;  // fetch held while ID stalls
  logic        cancel;     // outstanding data belongs to a redirected stream

  logic misaligned;
  logic present;
  logic discard;

  assign misaligned = (pc[1:0] != 2'b00);

  // A redirect or reset in the same cycle overrides any presentation.
  assign present = ~rst & ~redirect_valid &
                   (((state == S_REQ) & misaligned) |
                    ((state == S_WAIT_DATA) & inst_data_ok & ~cancel) |
                    (state == S_HOLD));

  assign discard = (state == S_WAIT_DATA) & inst_data_ok & (cancel | redirect_valid);

  // Bus side. Once the request sits in WAIT_ADDR it is held even across a
  // redirect, and its address comes from req_addr because pc may move on.
  assign inst_wr    = 1'b0;
  assign inst_size  = 2'b10;
  assign inst_wdata = 32'd0;
  assign inst_req   = ~rst & (((state == S_REQ) & ~misaligned & ~redirect_valid) |
                              (state == S_WAIT_ADDR));
  assign inst_addr  = (state == S_WAIT_ADDR) ? req_addr : pc;

  // IF/ID side.
  assign IF_stall          = ~present;
  assign IF_invalid        = ~rst & redirect_valid;
  assign IF_out_PC         = rst ? RESET_PC : pc;
  assign IF_AdEF_exception = present & misaligned;
  assign IF_bad_inst       = IF_AdEF_exception ? pc : 32'd0;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    IF_inst = 32'd0;
    if (present) begin
      case (state)
        S_WAIT_DATA: IF_inst = inst_rdata;
        S_HOLD:      IF_inst = hold_inst;
        default:     IF_inst = 32'd0;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      hold_inst <= 32'd0;
      cancel    <= 1'b0;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
      case (state)
        S_WAIT_ADDR: begin
          cancel <= 1'b1;
          if (inst_addr_ok) state <= S_WAIT_DATA;
        end
        S_WAIT_DATA: begin
          // Data arriving together with the redirect is simply dropped.
          if (inst_data_ok) begin
            cancel <= 1'b0;
            state  <= S_REQ;
          end else begin
            cancel <= 1'b1;
          end
        end
        default: state <= S_REQ;  // REQ / HOLD: drop anything held
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (misaligned) begin
            if (!ID_stall) begin
              pc <= pc + PC_STEP;
            end else begin
              hold_inst <= 32'd0;
              state     <= S_HOLD;
            end
          end else if (inst_addr_ok) begin
            state <= S_WAIT_DATA;
          end else begin
            req_addr <= pc;
            state    <= S_WAIT_ADDR;
          end
        end
        S_WAIT_ADDR: begin
          if (inst_addr_ok) state <= S_WAIT_DATA;
        end
        S_WAIT_DATA: begin
          if (inst_data_ok) begin
            if (cancel) begin
              cancel <= 1'b0;
              state  <= S_REQ;
            end else if (!ID_stall) begin
              pc    <= pc + PC_STEP;
              state <= S_REQ;
            end else begin
              hold_inst <= inst_rdata;
              state     <= S_HOLD;
            end
          end
        end
        default: begin  // S_HOLD
          if (!ID_stall) begin
            pc    <= pc + PC_STEP;
            state <= S_REQ;
          end
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt  <= 32'd0;
      cancel_cnt <= 32'd0;
    end else begin
      if (present && !ID_stall) fetch_cnt <= fetch_cnt + 32'd1;
      if (discard) cancel_cnt <= cancel_cnt + 32'd1;
    end
  end
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage: owns the fetch PC and drives the SRAM-like instruction bus (req/addr_ok/data_ok).
- Produces the IF-side signals consumed by the IF/ID pipeline register: PC, AdEF flag, bad address, stall, invalidate.
- Supports stall back-pressure from ID and redirects from branch/exception logic, with cancellation of in-flight fetches.

Parameters:
- RESET_PC, 32'hbfc00000, fetch PC after reset.
- PC_STEP, 4, PC increment per completed fetch.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ID_stall  in  1  ID cannot accept; IF/ID holds its contents
- redirect_valid  in  1  branch/exception redirect this cycle
- redirect_pc  in  32  redirect target
- inst_req  out  1  bus request
- inst_wr  out  1  tied 0
- inst_size  out  2  tied 2'b10
- inst_addr  out  32  request address
- inst_wdata  out  32  tied 0
- inst_addr_ok  in  1  address accepted
- inst_data_ok  in  1  read data returned
- inst_rdata  in  32  read data
- IF_out_PC  out  32  PC of presented fetch
- IF_inst  out  32  presented instruction
- IF_AdEF_exception  out  1  presented fetch is misaligned
- IF_bad_inst  out  32  faulting address (= IF_out_PC when AdEF, else 0)
- IF_stall  out  1  no valid fetch presented this cycle
- IF_invalid  out  1  flush IF/ID this cycle

Behaviour:
- Reset: pc=RESET_PC, state=REQ, cancel=0. Outputs: inst_req=0, IF_stall=1, IF_invalid=0, IF_out_PC=RESET_PC, IF_inst=0, IF_AdEF_exception=0, IF_bad_inst=0. The first request is issued the cycle after rst deasserts.
- At most one outstanding bus transaction.
- inst_req, once asserted, stays high with inst_addr stable until inst_addr_ok.
- States:
  - REQ: if pc[1:0]!=0, issue no request. Present an AdEF fetch: IF_stall=0, IF_inst=0, IF_bad_inst=pc. If ~ID_stall, pc+=PC_STEP; otherwise go to HOLD. If aligned, inst_req=1, inst_addr=pc. addr_ok in the same cycle -> WAIT_DATA; otherwise -> WAIT_ADDR.
  - WAIT_ADDR: keep the request. On addr_ok -> WAIT_DATA.
  - WAIT_DATA: on data_ok with cancel=0, present {pc, inst_rdata}, IF_stall=0. If ~ID_stall, pc+=PC_STEP and -> REQ; otherwise latch into the hold buffer and -> HOLD. On data_ok with cancel=1, discard the data, clear cancel, -> REQ.
  - HOLD: present the buffered fetch with IF_stall=0. When ~ID_stall, pc+=PC_STEP and -> REQ.
- IF_stall=1 in every cycle that does not present a fetch.
- A new request may be issued in the cycle after a fetch completes (REQ). data_ok and a new req never coincide.
- Redirect (highest priority), IF_invalid=redirect_valid, IF_stall=1 that cycle:
  - REQ or HOLD: pc<=redirect_pc, drop the held fetch, -> REQ. A request driven in REQ that same cycle is suppressed.
  - WAIT_ADDR: keep req until addr_ok, set cancel=1, pc<=redirect_pc.
  - WAIT_DATA: set cancel=1, pc<=redirect_pc. If data_ok arrives in the same cycle, discard it and leave cancel=0.
  - A second redirect while cancel=1 only overwrites pc.
- PC arithmetic is 32-bit modulo; 0xfffffffc+4 wraps to 0.
- rst during any state aborts immediately to reset values. The bus controller is reset by the same rst.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds output ports fetch_cnt[31:0] (increments on each fetch presented and accepted, i.e. IF_stall=0 & ~ID_stall) and cancel_cnt[31:0] (increments on each discarded data_ok). Both reset to 0 and wrap modulo 2^32.
- Undefined: ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset release, addr_ok same cycle, data_ok 1 cycle later, ID_stall=0 -> inst_addr 0xbfc00000 then 0xbfc00004. IF_out_PC follows with IF_stall=0 only on data_ok cycles.
- ID_stall=1 held 3 cycles at data_ok for 0xbfc00008 -> IF_stall=0 with PC 0xbfc00008 for 4 cycles. No inst_req until ID_stall falls, then 0xbfc0000c is requested.
- Redirect to 0x80000100 in WAIT_DATA, data_ok 2 cycles later -> IF_invalid pulse, returned data discarded (cancel_cnt=1), next inst_addr=0x80000100.
- addr_ok withheld 4 cycles, redirect to 0x80000200 in cycle 2 -> inst_addr stays at the old PC until addr_ok. Data discarded, next request 0x80000200.
- Redirect to 0x80000002 -> no inst_req, IF_AdEF_exception=1, IF_bad_inst=0x80000002, IF_inst=0 for one accepted cycle. Next pc is 0x80000006, also AdEF.
- rst asserted in WAIT_DATA -> next cycle all outputs at reset values, followed by a request to 0xbfc00000.
